jam_cost_rom_arbiter: RTL and testbench
=======================================

Name: jam_cost_rom_arbiter

Overview:
- Shares the single cost-ROM read port (W/J address out, 7-bit Cost back) between NREQ job-assignment evaluation engines.
- Grants are round-robin at burst granularity, so one engine fetches a complete permutation row-set uninterrupted.
- Absorbs the ROM's registered-address latency and returns each Cost word tagged with the requester ID.
- Sits between the permutation engines and the cost ROM.

Parameters:
NREQ, 4, number of requesters (2..8)
BURST_MAX, 8, maximum beats per grant; the beat that reaches this count ends the burst
IDLE_MAX, 4, consecutive cycles an owner may hold GNT with REQ low before the grant is revoked

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-low (asserted when 0)
REQ  in  NREQ  per-requester beat request
REQ_W  in  3*NREQ  worker index per requester; slice r = [3r+2:3r]
REQ_J  in  3*NREQ  job index per requester; same slicing
REQ_LAST  in  NREQ  marks the final beat of a burst
GNT  out  NREQ  one-hot owner indication; registered
W  out  3  ROM worker address; registered
J  out  3  ROM job address; registered
Cost  in  7  ROM data; valid one cycle after the ROM samples W/J
RVALID  out  1  RDATA/RID valid; registered
RID  out  3  requester ID of RDATA
RDATA  out  7  returned cost
ABORT  out  NREQ  one-cycle pulse; that requester's grant was revoked

Behaviour:
- Reset (RST=0, async): state IDLE, GNT=0, W=0, J=0, RVALID=0, RID=0, RDATA=0, ABORT=0, RR pointer=0, beat count=0, idle count=0, both return-pipe stages invalid.
- States: IDLE, BURST.
- IDLE:
  - If any REQ is high, pick the first requester at or after the RR pointer, wrapping modulo NREQ.
  - At the edge: GNT <= onehot(pick), state <= BURST, beat count <= 0.
  - No beat is accepted in IDLE.
- BURST:
  - A beat is accepted in a cycle with GNT[o]=1 and REQ[o]=1. At that edge: W <= REQ_W[o], J <= REQ_J[o], beat count +1, idle count <= 0, and a {valid, o} tag enters pipe stage 1.
  - Burst end occurs on an accepted beat with REQ_LAST[o]=1, or on the beat that makes the count equal BURST_MAX. At that edge:
    - RR pointer <= o+1 (mod NREQ).
    - If any REQ other than o is high, GNT moves directly to the next pick (no bubble) and state stays BURST with count 0.
    - Otherwise GNT <= 0 and state <= IDLE.
  - Owner REQ low: idle count +1 each cycle. On the edge where it would reach IDLE_MAX:
    - ABORT[o] pulses for one cycle and the RR pointer advances.
    - Arbitration then proceeds as for burst end.
- W/J hold their value when no beat is accepted.
- Return path (Cost is valid in the cycle after the ROM registers W/J):
  - The tag shifts stage 1 -> stage 2 at the next edge.
  - At the following edge: RVALID <= stage2.valid, and when valid, RID <= stage2.id and RDATA <= Cost.
  - Accept edge k gives RVALID high after edge k+2; latency is 2 cycles from accept.
  - Sustained throughput is 1 beat/cycle. Return order equals accept order.
- The return pipe keeps draining after a burst ends, an ABORT, or an owner switch. In-flight beats are always returned.
- Requests from the same requester are never interleaved.
- REQ_W/REQ_J of non-owners are ignored.
- Simultaneous events: LAST on the BURST_MAX beat counts as one burst end. ABORT cannot coincide with an accepted beat, because an accepted beat clears the idle count.
- Reset asserted mid-burst clears everything immediately, including in-flight tags. Partial bursts are not resumed.
- NREQ=1: the RR pointer stays 0, and the same requester is re-granted once REQ is high again.

Test Plan:
- Single burst: ROM entry (w,j) = 8w+j. Requester 0 issues 8 beats of W=2, J=0..7 with LAST on beat 8 -> GNT=0001 one cycle after REQ; RVALID for 8 consecutive cycles starting 2 cycles after the first accept, RDATA=16..23, RID=0; then GNT=0 and state IDLE.
- Contention: REQ=1111 held, each burst 3 beats with LAST -> grant order 0,1,2,3,0, with no idle cycle between bursts; RID sequence 0,0,0,1,1,1,2,2,2,3,3,3.
- BURST_MAX cut: requester 2 holds REQ with LAST never set for 10 beats -> grant ends after beat 8; requester 2 is re-granted for the remaining beats only if no other REQ is pending.
- Stall and abort: owner 1 accepts 2 beats, then drops REQ for 4 cycles -> ABORT=0010 for exactly one cycle; both in-flight beats still return with RID=1; GNT moves to the pending requester 3.
- Async reset mid-burst: RST=0 between edges during beat 5 -> all outputs 0 immediately, with no RVALID afterwards. After release, the first grant goes to the lowest pending index (pointer reset to 0).
- Address stability: 3 idle cycles between beats inside one burst -> W/J hold the last accepted values; no extra RVALID pulses.

Source files
------------

// File: rtl/jam_cost_rom_arbiter_if.sv
// Bus between the permutation engines plus cost ROM (master) and the
// cost-ROM arbiter (slave).
interface jam_cost_rom_arbiter_if #(
    parameter int NREQ = 4
);
    // Handshake: requester r presents REQ[r] with REQ_W/REQ_J/REQ_LAST slice r
    // and holds them until a rising CLK edge where GNT[r] and REQ[r] are both
    // high; that edge transfers the beat. RVALID qualifies RID/RDATA for exactly
    // one cycle, there is no back-pressure on the return side.
    logic [NREQ-1:0]   REQ;
    logic [3*NREQ-1:0] REQ_W;
    logic [3*NREQ-1:0] REQ_J;
    logic [NREQ-1:0]   REQ_LAST;
    logic [NREQ-1:0]   GNT;
    logic [2:0]        W;
    logic [2:0]        J;
    logic [6:0]        Cost;
    logic              RVALID;
    logic [2:0]        RID;
    logic [6:0]        RDATA;
    logic [NREQ-1:0]   ABORT;

    modport master (
        output REQ, REQ_W, REQ_J, REQ_LAST, Cost,
        input  GNT, W, J, RVALID, RID, RDATA, ABORT
    );

    modport slave (
        input  REQ, REQ_W, REQ_J, REQ_LAST, Cost,
        output GNT, W, J, RVALID, RID, RDATA, ABORT
    );
endinterface

// File: rtl/jam_cost_rom_arbiter.sv
// Round-robin, burst-granular arbiter for the shared cost-ROM read port with a
// two-stage tag pipe that returns each Cost word labelled with its requester.
module jam_cost_rom_arbiter #(
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 8,
    parameter int IDLE_MAX  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    jam_cost_rom_arbiter_if.slave  bus,
    output logic                   dbg_state
);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int IW = $clog2(IDLE_MAX + 1);

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] abort_q, abort_d;
    logic [2:0]      own_q, own_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [2:0]      w_q, w_d, j_q, j_d;
    logic            s1_v_q, s1_v_d, s2_v_q;
    logic [2:0]      s1_id_q, s1_id_d, s2_id_q;
    logic            rvalid_q;
    logic [2:0]      rid_q;
    logic [6:0]      rdata_q;

    logic            owner_req, owner_last, release_v;
    logic [2:0]      own_w, own_j, ptr_inc, nxt;
    logic [NREQ-1:0] others;

    // First set bit of r at or after start, wrapping; callers guarantee |r.
    function automatic logic [2:0] pick(input logic [NREQ-1:0] r, input logic [2:0] start);
        logic [2:0] sel;
        int         idx;
        sel = start;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NREQ;
            if (|(r & (NREQ'(1) << idx))) sel = 3'(idx);
        end
        return sel;
    endfunction

    always_comb begin
        own_w = 3'd0;
        own_j = 3'd0;
        for (int r = 0; r < NREQ; r++) begin
            if (gnt_q[r]) begin
                own_w = bus.REQ_W[3*r +: 3];
                own_j = bus.REQ_J[3*r +: 3];
            end
        end
    end

    assign owner_req  = |(bus.REQ & gnt_q);
    assign owner_last = |(bus.REQ_LAST & gnt_q);
    assign others     = bus.REQ & ~gnt_q;
    assign ptr_inc    = (own_q == 3'(NREQ - 1)) ? 3'd0 : own_q + 3'd1;
    assign nxt        = pick(others, ptr_inc);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        own_d     = own_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        idle_d    = idle_q;
        w_d       = w_q;
        j_d       = j_q;
        s1_v_d    = 1'b0;
        s1_id_d   = s1_id_q;
        abort_d   = '0;
        release_v = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|bus.REQ) begin
                    own_d   = pick(bus.REQ, ptr_q);
                    gnt_d   = NREQ'(1) << own_d;
                    state_d = S_BURST;
                    beat_d  = '0;
                    idle_d  = '0;
                end
            end
            S_BURST: begin
                if (owner_req) begin
                    w_d       = own_w;
                    j_d       = own_j;
                    beat_d    = beat_q + BW'(1);
                    idle_d    = '0;
                    s1_v_d    = 1'b1;
                    s1_id_d   = own_q;
                    release_v = owner_last || (beat_q == BW'(BURST_MAX - 1));
                end else if (idle_q == IW'(IDLE_MAX - 1)) begin
                    abort_d   = gnt_q;
                    release_v = 1'b1;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
                // Burst end and abort share the hand-over: straight to the next
                // pending requester without a bubble, else back to IDLE.
                if (release_v) begin
                    ptr_d  = ptr_inc;
                    beat_d = '0;
                    idle_d = '0;
                    if (|others) begin
                        own_d = nxt;
                        gnt_d = NREQ'(1) << nxt;
                    end else begin
                        gnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            abort_q <= '0;
            own_q   <= 3'd0;
            ptr_q   <= 3'd0;
            beat_q  <= '0;
            idle_q  <= '0;
            w_q     <= 3'd0;
            j_q     <= 3'd0;
            s1_v_q  <= 1'b0;
            s1_id_q <= 3'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            abort_q <= abort_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            idle_q  <= idle_d;
            w_q     <= w_d;
            j_q     <= j_d;
            s1_v_q  <= s1_v_d;
            s1_id_q <= s1_id_d;
        end
    end

    // Stage 2 lines up with the cycle in which the ROM drives Cost for the beat.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s2_v_q   <= 1'b0;
            s2_id_q  <= 3'd0;
            rvalid_q <= 1'b0;
            rid_q    <= 3'd0;
            rdata_q  <= 7'd0;
        end else begin
            s2_v_q   <= s1_v_q;
            s2_id_q  <= s1_id_q;
            rvalid_q <= s2_v_q;
            if (s2_v_q) begin
                rid_q   <= s2_id_q;
                rdata_q <= bus.Cost;
            end
        end
    end

    assign bus.GNT    = gnt_q;
    assign bus.W      = w_q;
    assign bus.J      = j_q;
    assign bus.RVALID = rvalid_q;
    assign bus.RID    = rid_q;
    assign bus.RDATA  = rdata_q;
    assign bus.ABORT  = abort_q;
    assign dbg_state  = (state_q == S_BURST);
endmodule

// File: tb/tb_jam_cost_rom_arbiter.sv
// Directed bench for jam_cost_rom_arbiter: engine queues drive beats, a ROM
// model returns 8w+j, and a monitor checks returns against a predicted queue.
module tb_jam_cost_rom_arbiter;
    localparam int NREQ      = 4;
    localparam int BURST_MAX = 8;
    localparam int IDLE_MAX  = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic dbg_state;

    jam_cost_rom_arbiter_if #(.NREQ(NREQ)) bus ();

    jam_cost_rom_arbiter #(.NREQ(NREQ), .BURST_MAX(BURST_MAX), .IDLE_MAX(IDLE_MAX)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    // Cost ROM: registers W/J, entry (w,j) = 8w+j.
    always @(posedge CLK) bus.Cost <= {1'b0, bus.W, bus.J};

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];             // {rid, rdata}
    logic [6:0] engq[NREQ][$];        // {last, w, j}
    logic [NREQ-1:0] gseq[$];
    logic [NREQ-1:0] eseq[$];
    int g0, r0, rv_last, rv_cnt, ab_cnt;
    logic [NREQ-1:0] ab_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int r, input int w, input int j, input bit last);
        engq[r].push_back({last, 3'(w), 3'(j)});
    endtask

    task automatic expect_beat(input int rid, input int w, input int j);
        exp_q.push_back({3'(rid), 7'(8 * w + j)});
    endtask

    function automatic bit eng_empty();
        int n = 0;
        for (int r = 0; r < NREQ; r++) n += engq[r].size();
        return n == 0;
    endfunction

    // Engine model: a beat leaves its queue on an edge where GNT and REQ were high.
    initial begin : engine
        logic [NREQ-1:0] take;
        bus.REQ = '0; bus.REQ_W = '0; bus.REQ_J = '0; bus.REQ_LAST = '0;
        forever begin
            @(posedge CLK);
            take = bus.GNT & bus.REQ;
            #1;
            for (int r = 0; r < NREQ; r++) begin
                if (take[r] && engq[r].size() > 0) void'(engq[r].pop_front());
                if (engq[r].size() > 0) begin
                    bus.REQ[r]         = 1'b1;
                    bus.REQ_LAST[r]    = engq[r][0][6];
                    bus.REQ_W[3*r +: 3] = engq[r][0][5:3];
                    bus.REQ_J[3*r +: 3] = engq[r][0][2:0];
                end else begin
                    bus.REQ[r]      = 1'b0;
                    bus.REQ_LAST[r] = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(negedge CLK);
            if (bus.RVALID === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rdata_unexpected: got RID=%0d RDATA=%0d, required no RVALID", bus.RID, bus.RDATA);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.RID, bus.RDATA} !== e) begin
                        n_err++;
                        $display("FAIL rdata: got RID=%0d RDATA=%0d, required RID=%0d RDATA=%0d",
                                 bus.RID, bus.RDATA, e[9:7], e[6:0]);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        #2 RST = 1'b0;
        for (int r = 0; r < NREQ; r++) engq[r].delete();
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    // Follows one scenario until everything drains, recording compressed GNT history.
    task automatic trace(input int budget);
        logic [NREQ-1:0] g;
        int cyc;
        bit done;
        gseq.delete();
        g0 = -1; r0 = -1; rv_last = -1; rv_cnt = 0; ab_cnt = 0; ab_val = '0;
        cyc = 0; done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge CLK);
            #1;
            g = bus.GNT;
            if (cyc == 0 || g != gseq[gseq.size()-1]) gseq.push_back(g);
            if (g != '0 && g0 < 0) g0 = cyc;
            if (bus.RVALID) begin
                if (r0 < 0) r0 = cyc;
                rv_last = cyc;
                rv_cnt++;
            end
            if (bus.ABORT != '0) begin
                ab_cnt++;
                ab_val |= bus.ABORT;
            end
            if (cyc > 0 && eng_empty() && dbg_state == 1'b0 && exp_q.size() == 0 && !bus.RVALID) done = 1'b1;
            cyc++;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL trace_timeout: got no drain within %0d cycles, required drain", budget);
        end
    endtask

    task automatic check_seq(input string name);
        check({name, "_len"}, gseq.size(), eseq.size());
        for (int i = 0; i < eseq.size() && i < gseq.size(); i++)
            check($sformatf("%s_gnt%0d", name, i), 32'(gseq[i]), 32'(eseq[i]));
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_gnt"},    32'(bus.GNT),    0);
        check({name, "_w"},      32'(bus.W),      0);
        check({name, "_j"},      32'(bus.J),      0);
        check({name, "_rvalid"}, 32'(bus.RVALID), 0);
        check({name, "_rid"},    32'(bus.RID),    0);
        check({name, "_rdata"},  32'(bus.RDATA),  0);
        check({name, "_abort"},  32'(bus.ABORT),  0);
        check({name, "_state"},  32'(dbg_state),  0);
    endtask

    initial begin : main
        #1 RST = 1'b0;
        @(negedge CLK);
        check_outputs_zero("reset");
        RST = 1'b1;
        @(negedge CLK);

        // Single burst: requester 0, W=2, J=0..7, LAST on beat 8.
        for (int k = 0; k < 8; k++) begin
            push_beat(0, 2, k, k == 7);
            expect_beat(0, 2, k);
        end
        trace(60);
        check("single_gnt_latency", g0, 1);
        check("single_rvalid_latency", r0 - g0, 3);
        check("single_rvalid_count", rv_cnt, 8);
        check("single_rvalid_run", rv_last - r0, 7);
        eseq = '{4'h0, 4'h1, 4'h0};
        check_seq("single");
        check("single_w_hold", 32'(bus.W), 2);
        check("single_j_hold", 32'(bus.J), 7);

        // Contention: all four request, 3-beat bursts; requester 0 has a second burst.
        do_reset();
        for (int r = 0; r < NREQ; r++)
            for (int k = 0; k < 3; k++) push_beat(r, r, k, k == 2);
        for (int k = 3; k < 6; k++) push_beat(0, 0, k, k == 5);
        for (int r = 0; r < NREQ; r++)
            for (int k = 0; k < 3; k++) expect_beat(r, r, k);
        for (int k = 3; k < 6; k++) expect_beat(0, 0, k);
        trace(100);
        eseq = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0};
        check_seq("contend");
        check("contend_rvalid_run", rv_last - r0, 14);

        // BURST_MAX cut with nobody else waiting: requester 2 is re-granted.
        for (int k = 0; k < 10; k++) begin
            push_beat(2, 4, k % 8, k == 9);
            expect_beat(2, 4, k % 8);
        end
        trace(80);
        eseq = '{4'h0, 4'h4, 4'h0, 4'h4, 4'h0};
        check_seq("cut_alone");
        check("cut_alone_count", rv_cnt, 10);

        // BURST_MAX cut with requester 3 pending: it gets the port in between.
        do_reset();
        for (int k = 0; k < 10; k++) push_beat(2, 5, k % 8, k == 9);
        push_beat(3, 6, 6, 1'b1);
        for (int k = 0; k < 8; k++) expect_beat(2, 5, k);
        expect_beat(3, 6, 6);
        expect_beat(2, 5, 0);
        expect_beat(2, 5, 1);
        trace(80);
        eseq = '{4'h0, 4'h4, 4'h8, 4'h4, 4'h0};
        check_seq("cut_shared");

        // Stall and abort: owner 1 takes 2 beats then goes quiet; 3 is waiting.
        do_reset();
        push_beat(1, 1, 5, 1'b0);
        push_beat(1, 1, 6, 1'b0);
        push_beat(3, 7, 7, 1'b1);
        expect_beat(1, 1, 5);
        expect_beat(1, 1, 6);
        expect_beat(3, 7, 7);
        trace(60);
        eseq = '{4'h0, 4'h2, 4'h8, 4'h0};
        check_seq("abort");
        check("abort_cycles", ab_cnt, 1);
        check("abort_value", 32'(ab_val), 32'h2);

        // Async reset during beat 5: only beats 1 and 2 have returned by then.
        do_reset();
        for (int k = 0; k < 8; k++) push_beat(0, 3, k, k == 7);
        expect_beat(0, 3, 0);
        expect_beat(0, 3, 1);
        begin
            int cnt = 0;
            do begin
                @(negedge CLK);
                cnt++;
            end while (engq[0].size() != 4 && cnt < 50);
            check("areset_reach_beat5", engq[0].size(), 4);
        end
        #2 RST = 1'b0;
        #1;
        check_outputs_zero("areset");
        check("areset_returned", exp_q.size(), 0);
        for (int r = 0; r < NREQ; r++) engq[r].delete();
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("areset_quiet_rvalid", 32'(bus.RVALID), 0);
        push_beat(3, 1, 1, 1'b1);
        push_beat(2, 2, 2, 1'b1);
        expect_beat(2, 2, 2);
        expect_beat(3, 1, 1);
        trace(60);
        eseq = '{4'h0, 4'h4, 4'h8, 4'h0};
        check_seq("areset_regrant");

        // Address stability: 3 idle cycles between two beats of one burst.
        push_beat(1, 5, 3, 1'b0);
        expect_beat(1, 5, 3);
        begin
            int cnt = 0;
            do begin
                @(negedge CLK);
                cnt++;
            end while (engq[1].size() != 0 && cnt < 50);
        end
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge CLK);
            check($sformatf("hold_w%0d", c), 32'(bus.W), 5);
            check($sformatf("hold_j%0d", c), 32'(bus.J), 3);
        end
        push_beat(1, 6, 1, 1'b1);
        expect_beat(1, 6, 1);
        trace(40);
        eseq = '{4'h2, 4'h0};
        check_seq("hold");
        check("hold_no_abort", ab_cnt, 0);
        check("hold_rvalid_count", rv_cnt, 1);
        check("hold_w_final", 32'(bus.W), 6);
        check("hold_j_final", 32'(bus.J), 1);

        repeat (4) @(negedge CLK);
        check("final_exp_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
